ov7670_capture_ctrl: RTL and testbench
======================================

Name: ov7670_capture_ctrl

Overview:
- Parametrised OV7670 frame-capture controller.
- Sits between the camera pixel bus and the frame-buffer write port.
- Assembles two-byte RGB565 pixels, optionally decimates 2:1 in both axes, and gates capture to whole frames under software control.
- Reports frame completion, a frame count and overrun errors.

Parameters:
- H_PIX, 320, sensor pixels per line (2*H_PIX bytes per href).
- V_LINES, 240, sensor lines per frame.
- DEC_LOG2, 0, decimation: 0 = none, 1 = keep every 2nd pixel and every 2nd line.
- ADDR_W, 17, write-address width; must hold (H_PIX>>DEC_LOG2)*(V_LINES>>DEC_LOG2)-1.
- BYTE_ORDER, 0, 0 = first byte goes to wData[15:8]; 1 = first byte goes to wData[7:0].

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cap_en  in  1  capture enable; sampled only at frame boundaries.
- href  in  1  camera line-valid.
- vsync  in  1  camera frame sync, active high.
- ov7670_data  in  8  camera byte bus.
- we  out  1  frame-buffer write strobe, one cycle per kept pixel.
- wAddr  out  ADDR_W  linear write address.
- wData  out  16  assembled pixel.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- frame_cnt  out  8  count of captured frames, wraps 255->0.
- busy  out  1  high in the SYNC and ACTIVE states.
- err_overrun  out  1  sticky; set on out-of-range data, cleared at each frame start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - we, wAddr, wData, frame_done, frame_cnt, busy, err_overrun all 0.
  - Internal counters and the vsync_d register all 0.
- vsync_d is vsync registered. vs_rise = vsync & ~vsync_d; vs_fall = ~vsync & vsync_d.
- FSM:
  - IDLE: on cap_en=1, go to WAIT_VS.
  - WAIT_VS: on vs_rise, go to SYNC. A frame already in progress is never captured partially.
  - SYNC: on vs_fall, go to ACTIVE. On entry to ACTIVE: clear the write pointer, line counter and err_overrun.
  - ACTIVE: capture. On vs_rise: pulse frame_done for one cycle, increment frame_cnt, then go to SYNC if cap_en=1, else IDLE.
  - Deasserting cap_en mid-frame does not abort the frame.
- Byte assembly (ACTIVE only):
  - While href=1, the byte counter increments every cycle.
  - Even byte latches into the first-byte half; odd byte latches into the second half.
  - href=0 clears the byte counter. An odd trailing byte is discarded with no write.
  - Pixel index = byte_cnt>>1.
- Keep rule:
  - A pixel is written when its second byte arrives and all of these hold: pixel index < H_PIX, line < V_LINES, and (DEC_LOG2=0 or both pixel index[0] and line[0] are 0).
- Write timing:
  - we is registered, high in the cycle after the second byte is sampled.
  - wData and wAddr are valid in that same cycle.
  - wAddr equals the write pointer. The pointer increments after each write; no multiplier is used.
  - we=0 in all other cycles, in all non-ACTIVE states, and while href=0.
- Line counter:
  - Increments on each href falling edge that follows at least one byte.
  - Saturates at V_LINES; it does not wrap.
- Overrun:
  - Any byte with pixel index >= H_PIX, or any line with line counter >= V_LINES, sets err_overrun. That data is dropped with no write.
  - err_overrun holds until the next entry to ACTIVE.
- Last write of a frame lands at wAddr = (H_PIX>>DEC_LOG2)*(V_LINES>>DEC_LOG2)-1.
- vs_rise and the last byte in the same cycle: the byte is discarded, frame_done still pulses.
- busy is registered from the state: high in SYNC and ACTIVE, low in IDLE and WAIT_VS.

Test Plan:
1. Defaults, BYTE_ORDER=0; cap_en=1; two full frames of 240 lines x 640 bytes, byte k of line n = (n+k)&0xFF → 76800 writes per frame, wAddr 0..76799, line 0 pixel 0 wData=16'h0001, frame_done pulses twice, frame_cnt=2, err_overrun=0.
2. cap_en raised mid-frame → no writes until after the next vs_rise/vs_fall pair; first write has wAddr=0.
3. DEC_LOG2=1, H_PIX=8, V_LINES=4 → exactly 8 writes per frame, wAddr 0..7, only pixels 0,2,4,6 of lines 0 and 2 written.
4. H_PIX=8; one line of 18 bytes → 8 writes, err_overrun=1 and stays 1 through frame_done; cleared after the next vs_fall.
5. href line of 7 bytes with H_PIX=8 → 3 writes, partial 4th pixel dropped, line counter +1.
6. Drop cap_en mid-frame → frame completes, frame_done pulses, FSM returns to IDLE, busy=0. Assert reset low mid-line → we=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/ov7670_capture_ctrl.sv
// rtl/ov7670_capture_ctrl.sv - OV7670 frame-capture controller: RGB565 assembly, 2:1 decimation, frame-gated writes
module ov7670_capture_ctrl #(
    parameter int H_PIX      = 320,
    parameter int V_LINES    = 240,
    parameter int DEC_LOG2   = 0,
    parameter int ADDR_W     = 17,
    parameter int BYTE_ORDER = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        ov7670_data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              busy,
    output logic              err_overrun
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, SYNC, ACTIVE} state_t;

    // Byte counter has headroom past 2*H_PIX so out-of-range pixels stay detectable before it saturates.
    localparam int BC_W = $clog2(2 * H_PIX) + 2;
    localparam int LC_W = $clog2(V_LINES + 1);
    localparam logic [BC_W-1:0] H_LIM = BC_W'(H_PIX);
    localparam logic [LC_W-1:0] V_LIM = LC_W'(V_LINES);

    state_t state, state_next;

    logic              vsync_d;
    logic [BC_W-1:0]   byte_cnt;
    logic [BC_W-1:0]   pix_idx;
    logic [LC_W-1:0]   line_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [7:0]        first_byte;

    logic vs_rise, vs_fall;
    logic busy_next, enter_active, frame_end;
    logic byte_ok, out_of_range, keep_dec, wr;

    assign vs_rise = vsync & ~vsync_d;
    assign vs_fall = ~vsync & vsync_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cap_en)  state_next = WAIT_VS;
            WAIT_VS: if (vs_rise) state_next = SYNC;
            SYNC:    if (vs_fall) state_next = ACTIVE;
            ACTIVE:  if (vs_rise) state_next = cap_en ? SYNC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_next    = (state_next == SYNC) || (state_next == ACTIVE);
        enter_active = (state == SYNC) && vs_fall;
        frame_end    = (state == ACTIVE) && vs_rise;
    end

    // A byte coinciding with the closing vsync edge belongs to no frame and is dropped.
    assign byte_ok      = (state == ACTIVE) && !vs_rise && href;
    assign pix_idx      = {1'b0, byte_cnt[BC_W-1:1]};
    assign out_of_range = (pix_idx >= H_LIM) || (line_cnt >= V_LIM);
    assign keep_dec     = (DEC_LOG2 == 0) || (!pix_idx[0] && !line_cnt[0]);
    assign wr           = byte_ok && byte_cnt[0] && !out_of_range && keep_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_d     <= 1'b0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            wr_ptr      <= '0;
            first_byte  <= '0;
            we          <= 1'b0;
            wAddr       <= '0;
            wData       <= '0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            busy       <= busy_next;
            frame_done <= frame_end;
            we         <= wr;

            if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (state != ACTIVE || !href) begin
                byte_cnt <= '0;
            end else if (byte_cnt != {BC_W{1'b1}}) begin
                byte_cnt <= byte_cnt + BC_W'(1);
            end

            if (enter_active) begin
                line_cnt <= '0;
            end else if (state == ACTIVE && !href && byte_cnt != '0 && line_cnt < V_LIM) begin
                line_cnt <= line_cnt + LC_W'(1);
            end

            if (byte_ok && !byte_cnt[0]) begin
                first_byte <= ov7670_data;
            end

            if (enter_active) begin
                wr_ptr <= '0;
            end else if (wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            if (wr) begin
                wAddr <= wr_ptr;
                wData <= (BYTE_ORDER != 0) ? {ov7670_data, first_byte}
                                           : {first_byte, ov7670_data};
            end

            if (enter_active) begin
                err_overrun <= 1'b0;
            end else if (byte_ok && out_of_range) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// tb/tb_ov7670_capture_ctrl.sv - directed bench for ov7670_capture_ctrl (plain and decimating instances)
module tb_ov7670_capture_ctrl;

    logic       clk = 1'b0;
    logic       reset, cap_en, href, vsync;
    logic [7:0] d;

    logic        a_we, a_fd, a_busy, a_err;
    logic [7:0]  a_addr, a_fc;
    logic [15:0] a_data;
    logic        b_we, b_fd, b_busy, b_err;
    logic [7:0]  b_addr, b_fc;
    logic [15:0] b_data;

    always #5 clk = ~clk;

    ov7670_capture_ctrl #(.H_PIX(8), .V_LINES(4), .DEC_LOG2(0), .ADDR_W(8), .BYTE_ORDER(0)) dut_a (
        .clk(clk), .reset(reset), .cap_en(cap_en), .href(href), .vsync(vsync), .ov7670_data(d),
        .we(a_we), .wAddr(a_addr), .wData(a_data), .frame_done(a_fd), .frame_cnt(a_fc),
        .busy(a_busy), .err_overrun(a_err)
    );

    ov7670_capture_ctrl #(.H_PIX(8), .V_LINES(4), .DEC_LOG2(1), .ADDR_W(8), .BYTE_ORDER(1)) dut_b (
        .clk(clk), .reset(reset), .cap_en(cap_en), .href(href), .vsync(vsync), .ov7670_data(d),
        .we(b_we), .wAddr(b_addr), .wData(b_data), .frame_done(b_fd), .frame_cnt(b_fc),
        .busy(b_busy), .err_overrun(b_err)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [23:0] qa[$];
    logic [23:0] qb[$];
    logic [23:0] ea, eb;
    int wr_a = 0, wr_b = 0, fd_a = 0, fd_b = 0;
    logic err_at_fd_a = 1'b0, err_at_fd_b = 1'b0;
    int a_ptr = 0, b_ptr = 0, ln = 0;
    bit capturing = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write is matched against the expected (addr,data) queue built by the stimulus.
    always @(negedge clk) begin
        if (a_we) begin
            wr_a++;
            chk("a_write_expected", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                chk("a_waddr", {24'd0, a_addr}, {24'd0, ea[23:16]});
                chk("a_wdata", {16'd0, a_data}, {16'd0, ea[15:0]});
            end
        end
        if (b_we) begin
            wr_b++;
            chk("b_write_expected", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                chk("b_waddr", {24'd0, b_addr}, {24'd0, eb[23:16]});
                chk("b_wdata", {16'd0, b_data}, {16'd0, eb[15:0]});
            end
        end
        if (a_fd) begin fd_a++; err_at_fd_a = a_err; end
        if (b_fd) begin fd_b++; err_at_fd_b = b_err; end
    end

    task automatic cyc(input logic h, input logic v, input logic [7:0] x);
        href = h; vsync = v; d = x;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vs_pulse();
        repeat (3) cyc(1'b0, 1'b1, 8'h00);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic start_frame();
        a_ptr = 0; b_ptr = 0; ln = 0; capturing = 1'b1; wr_a = 0; wr_b = 0;
    endtask

    // Byte k of a line is (seed+k); last_vs raises vsync together with the final byte.
    task automatic send_line(input int seed, input int nbytes, input bit last_vs);
        int npix;
        logic [7:0] b0, b1;
        npix = nbytes / 2;
        if (last_vs && (nbytes % 2 == 0)) npix--;
        if (capturing) begin
            for (int p = 0; p < npix; p++) begin
                b0 = 8'(seed + 2 * p);
                b1 = 8'(seed + 2 * p + 1);
                if (p < 8 && ln < 4) begin
                    qa.push_back({8'(a_ptr), b0, b1});
                    a_ptr++;
                    if (p % 2 == 0 && ln % 2 == 0) begin
                        qb.push_back({8'(b_ptr), b1, b0});
                        b_ptr++;
                    end
                end
            end
        end
        for (int k = 0; k < nbytes; k++) begin
            cyc(1'b1, (last_vs && k == nbytes - 1), 8'(seed + k));
        end
        if (capturing && nbytes > 0 && ln < 4) ln++;
        if (last_vs) begin
            repeat (2) cyc(1'b0, 1'b1, 8'h00);
            repeat (3) cyc(1'b0, 1'b0, 8'h00);
        end else begin
            idle(2);
        end
    endtask

    initial begin
        reset = 1'b0; cap_en = 1'b0; href = 1'b0; vsync = 1'b0; d = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_we", {31'd0, a_we}, 32'd0);
        chk("rst_a_addr", {24'd0, a_addr}, 32'd0);
        chk("rst_a_data", {16'd0, a_data}, 32'd0);
        chk("rst_a_fd", {31'd0, a_fd}, 32'd0);
        chk("rst_a_fc", {24'd0, a_fc}, 32'd0);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_a_err", {31'd0, a_err}, 32'd0);
        chk("rst_b_we", {31'd0, b_we}, 32'd0);
        reset = 1'b1;
        idle(2);

        // Frame in flight while disabled, cap_en raised mid-frame: nothing may be captured.
        vs_pulse();
        send_line(0, 16, 1'b0);
        send_line(1, 16, 1'b0);
        cap_en = 1'b1;
        idle(2);
        chk("busy_wait_vs", {31'd0, a_busy}, 32'd0);
        send_line(2, 16, 1'b0);
        send_line(3, 16, 1'b0);
        chk("a_no_write_partial", wr_a, 32'd0);
        chk("b_no_write_partial", wr_b, 32'd0);
        vs_pulse();
        chk("busy_active", {31'd0, a_busy}, 32'd1);

        // Frame 1: four clean lines.
        start_frame();
        for (int n = 0; n < 4; n++) send_line(n, 16, 1'b0);
        vs_pulse();
        chk("f1_a_writes", wr_a, 32'd32);
        chk("f1_b_writes", wr_b, 32'd8);
        chk("f1_a_q_empty", qa.size(), 32'd0);
        chk("f1_b_q_empty", qb.size(), 32'd0);
        chk("f1_a_fd", fd_a, 32'd1);
        chk("f1_a_fc", {24'd0, a_fc}, 32'd1);
        chk("f1_b_fc", {24'd0, b_fc}, 32'd1);
        chk("f1_a_err", {31'd0, a_err}, 32'd0);

        // Frame 2: overlong line, short odd line, extra line beyond V_LINES.
        start_frame();
        send_line(40, 18, 1'b0);
        chk("f2_a_err_set", {31'd0, a_err}, 32'd1);
        chk("f2_b_err_set", {31'd0, b_err}, 32'd1);
        send_line(41, 7, 1'b0);
        send_line(42, 16, 1'b0);
        send_line(43, 16, 1'b0);
        send_line(44, 16, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 8'h00);
        chk("f2_a_fd", fd_a, 32'd2);
        chk("f2_a_err_at_fd", {31'd0, err_at_fd_a}, 32'd1);
        chk("f2_b_err_at_fd", {31'd0, err_at_fd_b}, 32'd1);
        chk("f2_a_fc", {24'd0, a_fc}, 32'd2);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        chk("f2_a_err_clr", {31'd0, a_err}, 32'd0);
        chk("f2_b_err_clr", {31'd0, b_err}, 32'd0);
        chk("f2_a_writes", wr_a, 32'd27);
        chk("f2_b_writes", wr_b, 32'd8);

        // Frame 3: cap_en dropped mid-frame; last byte collides with vsync rise.
        start_frame();
        send_line(80, 16, 1'b0);
        cap_en = 1'b0;
        send_line(81, 16, 1'b0);
        send_line(82, 16, 1'b0);
        send_line(83, 16, 1'b1);
        idle(2);
        chk("f3_a_fd", fd_a, 32'd3);
        chk("f3_b_fd", fd_b, 32'd3);
        chk("f3_a_fc", {24'd0, a_fc}, 32'd3);
        chk("f3_a_busy_idle", {31'd0, a_busy}, 32'd0);
        chk("f3_b_busy_idle", {31'd0, b_busy}, 32'd0);
        chk("f3_a_writes", wr_a, 32'd31);
        chk("f3_b_writes", wr_b, 32'd8);
        chk("f3_a_q_empty", qa.size(), 32'd0);

        // Frame 4: asynchronous reset while a write strobe is high.
        capturing = 1'b0;
        cap_en = 1'b1;
        idle(2);
        vs_pulse();
        cyc(1'b1, 1'b0, 8'h12);
        cyc(1'b1, 1'b0, 8'h34);
        chk("f4_a_we", {31'd0, a_we}, 32'd1);
        chk("f4_a_data", {16'd0, a_data}, 32'h1234);
        chk("f4_a_addr", {24'd0, a_addr}, 32'd0);
        chk("f4_b_data", {16'd0, b_data}, 32'h3412);
        reset = 1'b0;
        #1;
        chk("arst_a_we", {31'd0, a_we}, 32'd0);
        chk("arst_a_data", {16'd0, a_data}, 32'd0);
        chk("arst_a_fc", {24'd0, a_fc}, 32'd0);
        chk("arst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("arst_b_we", {31'd0, b_we}, 32'd0);
        chk("arst_b_fc", {24'd0, b_fc}, 32'd0);
        href = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
